// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - banked word buffer between external memory and the PE array
// One operation per cycle: external single-bank access, PE-array wide write, or PE-array wide read.
module output_buffer #(
    parameter int NBANK = 32,
    parameter int DEPTH = 64,
    parameter int W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loading_ext_mem,
    input  logic               data_ext_mem,
    input  logic [5:0]         memory_bank_index,
    input  logic [15:0]        memory_bank_address,
    input  logic               loading_PEA,
    input  logic               calc_PEA,
    input  logic [NBANK*W-1:0] input_bus,
    output logic [NBANK*W-1:0] output_bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(NBANK);

    logic              addr_ok;
    logic              bank_ok;
    logic [AW-1:0]     addr_idx;
    logic [BW-1:0]     bank_sel;
    logic              ext_wr;
    logic              pe_wr;
    logic [NBANK*W-1:0] rd_flat;
    logic [NBANK*W-1:0] next_out;

    assign addr_ok  = memory_bank_address < 16'(DEPTH);
    assign bank_ok  = {1'b0, memory_bank_index} < 7'(NBANK);
    assign addr_idx = memory_bank_address[AW-1:0];
    assign bank_sel = memory_bank_index[BW-1:0];

    // Writes are qualified by rst so nothing lands on an edge seen while reset is held.
    assign ext_wr = rst & loading_ext_mem & data_ext_mem & bank_ok & addr_ok;
    assign pe_wr  = rst & ~loading_ext_mem & calc_PEA & addr_ok;

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic [W-1:0] mem [DEPTH];
        logic         we;

        assign we = pe_wr | (ext_wr & (bank_sel == BW'(i)));

        always_ff @(posedge clk) begin
            if (we) begin
                mem[addr_idx] <= (pe_wr) ? input_bus[i*W +: W] : input_bus[W-1:0];
            end
        end

        assign rd_flat[i*W +: W] = mem[addr_idx];
    end

    always_comb begin
        next_out = output_bus;
        if (loading_ext_mem) begin
            if (!data_ext_mem) begin
                next_out = '0;
                if (bank_ok && addr_ok) begin
                    next_out[W-1:0] = rd_flat[bank_sel*W +: W];
                end
            end
        end else if (calc_PEA) begin
            next_out = output_bus;
        end else if (loading_PEA) begin
            next_out = addr_ok ? rd_flat : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_bus <= '0;
        end else begin
            output_bus <= next_out;
        end
    end

endmodule

// File: tb/tb_output_buffer.sv
// tb/tb_output_buffer.sv - randomized self-checking bench for output_buffer
module tb_output_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         loading_ext_mem = 1'b0;
    logic         data_ext_mem = 1'b0;
    logic [5:0]   memory_bank_index = '0;
    logic [15:0]  memory_bank_address = '0;
    logic         loading_PEA = 1'b0;
    logic         calc_PEA = 1'b0;
    logic [511:0] input_bus = '0;
    logic [511:0] output_bus;

    int checks = 0;
    int errors = 0;

    logic [15:0]  ref_mem [32][64];
    logic [511:0] exp_out = '0;

    output_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .loading_ext_mem     (loading_ext_mem),
        .data_ext_mem        (data_ext_mem),
        .memory_bank_index   (memory_bank_index),
        .memory_bank_address (memory_bank_address),
        .loading_PEA         (loading_PEA),
        .calc_PEA            (calc_PEA),
        .input_bus           (input_bus),
        .output_bus          (output_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge, taken from the operation rules directly.
    task automatic model_edge();
        int idx;
        int adr;
        idx = int'(memory_bank_index);
        adr = int'(memory_bank_address);
        if (!rst) begin
            exp_out = '0;
        end else if (loading_ext_mem) begin
            if (data_ext_mem) begin
                if (idx < 32 && adr < 64) ref_mem[idx][adr] = input_bus[15:0];
            end else begin
                exp_out = '0;
                if (idx < 32 && adr < 64) exp_out[15:0] = ref_mem[idx][adr];
            end
        end else if (calc_PEA) begin
            if (adr < 64)
                for (int i = 0; i < 32; i++) ref_mem[i][adr] = input_bus[i*16 +: 16];
        end else if (loading_PEA) begin
            exp_out = '0;
            if (adr < 64)
                for (int i = 0; i < 32; i++) exp_out[i*16 +: 16] = ref_mem[i][adr];
        end
    endtask

    task automatic cyc(input logic e, input logic d, input logic [5:0] idx, input logic [15:0] a,
                       input logic p, input logic c, input logic [511:0] bus, input string tag);
        @(negedge clk);
        loading_ext_mem = e;
        data_ext_mem = d;
        memory_bank_index = idx;
        memory_bank_address = a;
        loading_PEA = p;
        calc_PEA = c;
        input_bus = bus;
        @(posedge clk);
        model_edge();
        #1;
        check(tag, output_bus, exp_out);
    endtask

    function automatic logic [511:0] rand_bus();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [511:0] ramp_bus(input logic [15:0] base);
        logic [511:0] b;
        for (int i = 0; i < 32; i++) b[i*16 +: 16] = base + 16'(i);
        return b;
    endfunction

    initial begin
        logic [511:0] b;
        logic [511:0] old_row;

        // Reset held with idle inputs: output stays zero throughout.
        #1 rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            #10;
            check("reset_hold", output_bus, '0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Fill every location so later reads have known contents.
        for (int a = 0; a < 64; a++) cyc(0, 0, 0, 16'(a), 0, 1, rand_bus(), "fill");

        // PE write then PE read of a ramp pattern at address 5.
        cyc(0, 0, 0, 16'd5, 0, 1, ramp_bus(16'h0100), "pe_write");
        cyc(0, 0, 0, 16'd5, 1, 0, '0, "pe_read");
        check("pe_ramp", output_bus, ramp_bus(16'h0100));

        // External write then read of bank 7 address 63; neighbour bank 6 untouched.
        b = rand_bus();
        b[15:0] = 16'hBEEF;
        cyc(1, 1, 6'd7, 16'd63, 0, 0, b, "ext_write");
        cyc(1, 0, 6'd7, 16'd63, 0, 0, '0, "ext_read");
        check("ext_beef", output_bus, {496'b0, 16'hBEEF});
        cyc(1, 0, 6'd6, 16'd63, 0, 0, '0, "ext_neighbour");

        // Out-of-range bank and address: write ignored, read returns zero.
        cyc(1, 1, 6'd40, 16'd3, 0, 0, {496'b0, 16'h1234}, "oor_bank_wr");
        cyc(1, 0, 6'd40, 16'd3, 0, 0, '0, "oor_bank_rd");
        check("oor_bank_zero", output_bus, '0);
        cyc(1, 1, 6'd4, 16'd64, 0, 0, {496'b0, 16'h1234}, "oor_addr_wr");
        cyc(1, 0, 6'd4, 16'd64, 0, 0, '0, "oor_addr_rd");
        cyc(0, 0, 0, 16'd3, 1, 0, '0, "oor_row3_intact");
        cyc(0, 0, 0, 16'h8003, 1, 0, '0, "oor_pe_hi_addr");
        cyc(0, 0, 0, 16'd3, 0, 1, rand_bus(), "oor_pe_hold");

        // External write wins over a simultaneous PE write.
        old_row = '0;
        for (int i = 0; i < 32; i++) old_row[i*16 +: 16] = ref_mem[i][2];
        b = rand_bus();
        b[15:0] = 16'hAAAA;
        cyc(1, 1, 6'd0, 16'd2, 0, 1, b, "prio_write");
        cyc(0, 0, 0, 16'd2, 1, 0, '0, "prio_read");
        old_row[15:0] = 16'hAAAA;
        check("prio_row", output_bus, old_row);

        // Randomized mix of all operations, idle cycles and out-of-range accesses.
        for (int n = 0; n < 400; n++) begin
            int k;
            logic [15:0] a;
            k = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 66));
            cyc(k inside {[0:2]}, k inside {[0:1]}, 6'($urandom_range(0, 35)), a,
                k inside {[5:7]} || k == 2, k inside {[3:4]} || k == 2, rand_bus(), "random");
        end

        // Reset pulse in the middle of a PE write burst.
        cyc(0, 0, 0, 16'd9, 1, 0, '0, "mid_pre_read");
        cyc(0, 0, 0, 16'd10, 0, 1, rand_bus(), "mid_burst0");
        cyc(0, 0, 0, 16'd11, 0, 1, rand_bus(), "mid_burst1");
        old_row = '0;
        for (int i = 0; i < 32; i++) old_row[i*16 +: 16] = ref_mem[i][12];
        @(negedge clk);
        calc_PEA = 1'b1;
        memory_bank_address = 16'd12;
        input_bus = rand_bus();
        #2 rst = 1'b0;
        #1 check("mid_async_zero", output_bus, '0);
        @(posedge clk);
        model_edge();
        #1 check("mid_reset_edge", output_bus, exp_out);
        @(negedge clk);
        calc_PEA = 1'b0;
        rst = 1'b1;
        cyc(0, 0, 0, 16'd12, 1, 0, '0, "mid_lost_write");
        check("mid_row12_old", output_bus, old_row);
        cyc(0, 0, 0, 16'd11, 1, 0, '0, "mid_row11_kept");
        cyc(0, 0, 0, 16'd0, 0, 0, '0, "idle_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst.
REQ-002 Parameter NBANK, default 32: number of banks, one per 16-bit lane of the bus.
REQ-003 Parameter DEPTH, default 64: words per bank.
REQ-004 Parameter W, default 16: word width in bits.
REQ-005 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 Port loading_ext_mem, input, 1 bit: external-memory access request to a single bank.
REQ-008 Port data_ext_mem, input, 1 bit: external access direction; 1 = write into buffer, 0 = read out of buffer.
REQ-009 Port memory_bank_index, input, 6 bits: bank selected for external access.
REQ-010 Port memory_bank_address, input, 16 bits: word address for every access type.
REQ-011 Port loading_PEA, input, 1 bit: read all banks at one address, for the PE array.
REQ-012 Port calc_PEA, input, 1 bit: PE-array result write into all banks.
REQ-013 Port input_bus, input, 512 bits: lane i = bits [16i+15:16i].
REQ-014 Port output_bus, output, 512 bits: registered read data, same lane mapping as input_bus.

Function
REQ-015 Storage SHALL be NBANK independent banks of DEPTH x W bits; bank i serves lane i.
REQ-016 An address is in range only when memory_bank_address < DEPTH; for DEPTH=64, bits [15:6] SHALL be zero.
REQ-017 A bank index is valid only when memory_bank_index < NBANK.
REQ-018 Only one operation SHALL execute per cycle, by priority: loading_ext_mem, then calc_PEA, then loading_PEA.
REQ-019 calc_PEA write: each lane i of input_bus SHALL be written to bank i at memory_bank_address on that edge; the data is readable from the next cycle.
REQ-020 loading_PEA read: output_bus lane i SHALL equal bank i at memory_bank_address, registered, with one cycle of latency.
REQ-021 External write (loading_ext_mem=1, data_ext_mem=1): input_bus[15:0] SHALL be written to bank memory_bank_index at memory_bank_address; no other bank changes.
REQ-022 External read (loading_ext_mem=1, data_ext_mem=0): output_bus[15:0] SHALL equal the selected word one cycle later; output_bus[511:16] SHALL be 0.
REQ-023 Any write with an out-of-range address or invalid bank index SHALL be ignored, with no memory change.
REQ-024 Any read with an out-of-range address or invalid bank index SHALL drive the affected lanes to 0.
REQ-025 When no control input is asserted, output_bus SHALL hold its last value and memory SHALL be unchanged.
REQ-026 A read in the cycle after a write to the same location SHALL return the newly written data.
REQ-027 The address SHALL NOT auto-increment; the controller supplies memory_bank_address every cycle.

Reset
REQ-028 While rst=0, output_bus SHALL be 0, asynchronously.
REQ-029 While rst=0, every write and read SHALL be blocked.
REQ-030 Memory contents SHALL NOT be cleared by reset and SHALL be retained through it.
REQ-031 Assertion of rst in the middle of an operation SHALL abort that operation; a write on the same edge as reset assertion SHALL NOT occur.
REQ-032 Operation SHALL resume on the first rising clk edge after rst returns to 1.

Verification
REQ-033 Reset: rst=0 with all inputs at 0 for 100 ns, then rst=1 -> output_bus = 0 throughout; no memory write occurs.
REQ-034 PE write/read: calc_PEA=1, address 5, lane i = 16'h0100+i; next cycle loading_PEA=1, address 5 -> one cycle later lane i = 16'h0100+i for all 32 lanes.
REQ-035 External write/read: loading_ext_mem=1, data_ext_mem=1, bank 7, address 63, input_bus[15:0]=16'hBEEF; next cycle data_ext_mem=0 -> output_bus = {496'b0, 16'hBEEF}, and bank 6 at address 63 is unchanged.
REQ-036 Out of range: bank index 40, or address 64, write 16'h1234 then read back -> read returns 0 and no bank is modified.
REQ-037 Priority: loading_ext_mem=1 (write, bank 0, address 2, data 16'hAAAA) and calc_PEA=1 on the same edge -> only bank 0 address 2 = 16'hAAAA; the other 31 banks keep their old data at address 2.
REQ-038 Reset mid-stream: rst=0 pulse during a calc_PEA burst -> output_bus = 0 at once; the write on the reset edge is lost; earlier data is retained and readable after release.
